// File: rtl/pio_sample_feeder.sv
// pio_sample_feeder
// Buffers a non-stallable sample stream in a small register FIFO and presents
// the oldest sample to a Nios input PIO. Each level change of ack_toggle pops
// one entry. pio_avail is high while the FIFO holds data. When the FIFO is
// full and nothing pops, an incoming sample is dropped and the sticky ovf flag
// is set.
//
// Optional feature: define PIO_SAMPLE_FEEDER_OVF_CNT_EN to build a saturating
// 16-bit dropped-sample counter on ovf_count. Without the macro, ovf_count is
// tied to zero.
module pio_sample_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  ack_toggle,
  input  logic                  clr_ovf,
  output logic [DATA_W-1:0]     pio_data,
  output logic                  pio_avail,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  ovf,
  output logic [15:0]           ovf_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Level constants at the width of the fill counter.
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO_C = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE_C  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_FULL_C = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Pointer increment constants.
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO_C = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Storage and state.
  logic [DATA_W-1:0]     mem_r [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   fill_r;
  logic                  ack_q_r;
  logic [DATA_W-1:0]     pio_data_r;
  logic                  pio_avail_r;
  logic                  ovf_r;

  // Per-cycle decisions and next-state values.
  logic                  pop_req_s;
  logic                  not_empty_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_nx_s;
  logic [DEPTH_LOG2-1:0] rd_ptr_nx_s;
  logic [DEPTH_LOG2-1:0] rd_ptr_inc_s;
  logic [DEPTH_LOG2:0]   fill_nx_s;
  logic [DATA_W-1:0]     pio_data_nx_s;
  logic                  ovf_nx_s;

  // Decide pop, push and drop for this cycle.
  // ack_toggle comes from a same-clock PIO, so a plain XOR against its
  // registered copy is enough to detect an edge; no synchronizer is needed.
  always_comb begin
    pop_req_s   = ack_toggle ^ ack_q_r;
    not_empty_s = (fill_r != LVL_ZERO_C);
    full_s      = (fill_r == LVL_FULL_C);
    // A request while empty is simply lost, never queued.
    pop_s       = pop_req_s & not_empty_s;
    // When full, a pop in the same cycle frees the slot the push needs.
    push_s      = s_valid & (~full_s | pop_s);
    drop_s      = s_valid & full_s & ~pop_s;
  end

  // Compute pointer and fill-level updates.
  always_comb begin
    rd_ptr_inc_s = rd_ptr_r + PTR_ONE_C;
    if (push_s) begin
      wr_ptr_nx_s = wr_ptr_r + PTR_ONE_C;
    end else begin
      wr_ptr_nx_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nx_s = rd_ptr_inc_s;
    end else begin
      rd_ptr_nx_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   fill_nx_s = fill_r + LVL_ONE_C;
      2'b01:   fill_nx_s = fill_r - LVL_ONE_C;
      default: fill_nx_s = fill_r;
    endcase
  end

  // Select the next head word.
  // With a single buffered entry, a push and a pop in the same cycle make the
  // incoming sample the new head before it is in the array, so bypass it. If
  // the FIFO drains completely, the last popped value stays on the PIO.
  always_comb begin
    if (push_s && !not_empty_s) begin
      pio_data_nx_s = s_data;
    end else if (pop_s && (fill_r == LVL_ONE_C)) begin
      if (push_s) begin
        pio_data_nx_s = s_data;
      end else begin
        pio_data_nx_s = pio_data_r;
      end
    end else if (pop_s) begin
      pio_data_nx_s = mem_r[rd_ptr_inc_s];
    end else begin
      pio_data_nx_s = pio_data_r;
    end
  end

  // Sticky overflow: a drop in the same cycle beats a clear.
  always_comb begin
    if (drop_s) begin
      ovf_nx_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_nx_s = 1'b0;
    end else begin
      ovf_nx_s = ovf_r;
    end
  end

  // Sample storage. The contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // Control state and registered outputs. Reset empties the FIFO at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= PTR_ZERO_C;
      rd_ptr_r    <= PTR_ZERO_C;
      fill_r      <= LVL_ZERO_C;
      ack_q_r     <= 1'b0;
      pio_data_r  <= {DATA_W{1'b0}};
      pio_avail_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nx_s;
      rd_ptr_r    <= rd_ptr_nx_s;
      fill_r      <= fill_nx_s;
      ack_q_r     <= ack_toggle;
      pio_data_r  <= pio_data_nx_s;
      pio_avail_r <= (fill_nx_s != LVL_ZERO_C);
      ovf_r       <= ovf_nx_s;
    end
  end

`ifdef PIO_SAMPLE_FEEDER_OVF_CNT_EN
  logic [15:0] ovf_cnt_r;
  logic [15:0] ovf_cnt_nx_s;

  // Saturating drop counter. A clear that coincides with a drop leaves the
  // count at 1, so that drop is still recorded.
  always_comb begin
    if (clr_ovf) begin
      if (drop_s) begin
        ovf_cnt_nx_s = 16'h0001;
      end else begin
        ovf_cnt_nx_s = 16'h0000;
      end
    end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_nx_s = ovf_cnt_r + 16'h0001;
    end else begin
      ovf_cnt_nx_s = ovf_cnt_r;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt_r <= 16'h0000;
    end else begin
      ovf_cnt_r <= ovf_cnt_nx_s;
    end
  end

  assign ovf_count = ovf_cnt_r;
`else
  assign ovf_count = 16'h0000;
`endif

  assign pio_data   = pio_data_r;
  assign pio_avail  = pio_avail_r;
  assign fill_level = fill_r;
  assign ovf        = ovf_r;

endmodule
